lcd_ctrl_param: RTL
===================

# lcd_ctrl_param

Parametrised image-buffer controller for the LCD datapath. After reset it loads a W×H image from a synchronous IROM into an internal pixel array, then executes one host command at a time on a movable 2×2 operation window. Commands cover shift, max/min/average fill, rotate, mirror, reload, recentre and write-out. WRITE streams the whole image to IRAM and pulses `done`. It generalises the fixed 8×8/8-bit controller to arbitrary power-of-two geometry and pixel width, and adds RELOAD, CENTER and explicit NOP handling.

## Interface
- DW, 8, pixel width in bits (≥2)
- IMG_W, 8, image width in pixels; power of two, ≥2
- IMG_H, 8, image height in pixels; power of two, ≥2
- AW, derived localparam = log2(IMG_W*IMG_H), not overridable
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  reset, asynchronous, active-high
- cmd  in  4  command code, sampled with cmd_valid
- cmd_valid  in  1  command strobe
- irom_q  in  DW  ROM read data, valid the cycle after irom_a/irom_rd
- irom_rd  out  1  ROM read enable
- irom_a  out  AW  ROM address, row-major (y*IMG_W + x)
- iram_valid  out  1  IRAM write strobe
- iram_a  out  AW  IRAM address, row-major
- iram_d  out  DW  IRAM write data
- busy  out  1  high = command not accepted
- done  out  1  one-cycle pulse ending WRITE

## Operation
- Operation point (x,y): x ∈ 1..IMG_W-1, y ∈ 1..IMG_H-1; reset/CENTER value (IMG_W/2, IMG_H/2). Window cells: TL=(x-1,y-1), TR=(x,y-1), BL=(x-1,y), BR=(x,y).
- States: LOAD, IDLE, EXEC (1-cycle commands), CALC, FILL (2-cycle commands), WRITE, DONE.
- Reset enters LOAD. LOAD reads all N=IMG_W*IMG_H pixels, then enters IDLE.
- Acceptance: cmd_valid & !busy, sampled in IDLE only. cmd_valid while busy is ignored, not queued.
- Codes:
  - 0000 WRITE
  - 0001/0010/0011/0100 shift up/down/left/right. At a limit there is no move, but the command still takes one cycle.
  - 0101 MAX, 0110 MIN, 0111 AVG: result written to all 4 window cells. AVG = floor(sum/4), sum kept at DW+2 bits, no overflow.
  - 1000 CCW: TL←TR, BL←TL, BR←BL, TR←BR.
  - 1001 CW: TL←BL, TR←TL, BR←TR, BL←BR.
  - 1010 MX: swap the two rows.
  - 1011 MY: swap the two columns.
  - 1100 RELOAD: re-enter LOAD. Op point is unchanged.
  - 1101 CENTER: op point returns to its reset value.
  - 1110/1111 NOP: busy for one cycle, no state change.
- All 4 cell updates of a command happen on one edge and use pre-edge values.

## Timing
- Reset values:
  - irom_rd=0, irom_a=0
  - iram_valid=0, iram_a=0, iram_d=0
  - done=0, busy=1
  - op point = centre
  - pixel array contents undefined until the load completes
- Cycle numbering for LOAD: cycle 1 is the first cycle after reset release (or after RELOAD is accepted).
  - irom_rd=1 in cycles 1..N, with irom_a=k in cycle k+1.
  - irom_q for address k is captured at the end of cycle k+2.
  - busy falls in cycle N+2; the block is IDLE from then.
- Command accepted at edge T:
  - busy=1 from cycle T+1.
  - EXEC commands (shift, CCW, CW, MX, MY, CENTER, NOP): busy=1 in T+1 only. A new command is accepted at the end of T+1 at the earliest.
  - MAX/MIN/AVG: busy=1 in T+1..T+2. The result is registered in CALC and written back in FILL.
  - WRITE: iram_valid=1 in T+1..T+N, with iram_a=k and iram_d=pixel[k] in cycle T+1+k. done=1 and busy=1 in T+N+1. busy=0 in T+N+2.
- iram_valid, irom_rd and done are 0 in every cycle not listed above.
- Reset asserted at any time, including mid-WRITE or mid-LOAD, aborts the current operation.
  - All outputs go to their reset values immediately (asynchronous).
  - A full LOAD restarts after release.
  - No partial IRAM writes are issued after reset asserts.

## Test plan
- Load and write-out, default params: ROM[a]=a, then WRITE.
  - busy falls 66 cycles after reset release.
  - iram_a/iram_d = 0..63 / 0..63 on consecutive cycles.
  - done pulses once, one cycle after iram_a=63.
- AVG at the default point (4,4): cells 27,28,35,36, sum 126.
  - WRITE then shows 31 at all four addresses and a at every other address a.
- Clamp and rotate: SU×5, SL×5, giving op point (1,1), then CW.
  - Cells 0,1,8,9 become TL=8, TR=0, BR=1, BL=9.
  - A following MX gives TL=9, TR=1, BL=8, BR=0.
- Busy and NOP: SR accepted, then cmd_valid=1 with MAX held during busy.
  - MAX is ignored and only SR executes.
  - Code 1110 gives busy for exactly 1 cycle and an unchanged image.
- Geometry IMG_W=16, IMG_H=4, DW=10, ROM[a]=1023-a:
  - Start point is (8,2).
  - MAX fills cells 23,24,39,40 with 1000.
  - CENTER after SR×3 returns the point to (8,2).
- Reset mid-WRITE (after iram_a=20):
  - iram_valid drops asynchronously and busy=1.
  - LOAD restarts from irom_a=0 and the op point returns to the centre.
  - No done pulse occurs.

Source files
------------

// File: rtl/lcd_ctrl_param.sv
// lcd_ctrl_param: loads a W x H image from IROM, runs 2x2-window host commands, streams the result to IRAM.
module lcd_ctrl_param #(
    parameter int DW    = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [3:0]                      cmd,
    input  logic                            cmd_valid,
    input  logic [DW-1:0]                   irom_q,
    output logic                            irom_rd,
    output logic [$clog2(IMG_W*IMG_H)-1:0]  irom_a,
    output logic                            iram_valid,
    output logic [$clog2(IMG_W*IMG_H)-1:0]  iram_a,
    output logic [DW-1:0]                   iram_d,
    output logic                            busy,
    output logic                            done
);
    localparam int N  = IMG_W * IMG_H;
    localparam int AW = $clog2(N);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [AW:0]    N_C  = (AW+1)'(N);
    localparam logic [AW:0]    R1   = (AW+1)'(1);
    localparam logic [AW-1:0]  LAST = AW'(N - 1);
    localparam logic [AW-1:0]  A1   = AW'(1);
    localparam logic [XW-1:0]  X1   = XW'(1);
    localparam logic [XW-1:0]  XMAX = XW'(IMG_W - 1);
    localparam logic [XW-1:0]  XC   = XW'(IMG_W / 2);
    localparam logic [YW-1:0]  Y1   = YW'(1);
    localparam logic [YW-1:0]  YMAX = YW'(IMG_H - 1);
    localparam logic [YW-1:0]  YC   = YW'(IMG_H / 2);

    typedef enum logic [2:0] {LOAD, IDLE, EXEC, CALC, FILL, WRITE, DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cmd_q, cmd_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [AW:0]     rcnt_q, rcnt_d;
    logic            cap_v_q;
    logic [AW-1:0]   cap_a_q;
    logic [DW-1:0]   res_q, res_d;
    logic            rd_q, rd_d, wv_q, wv_d, busy_q, busy_d, done_q, done_d;
    logic [AW-1:0]   ra_q, ra_d, wa_q, wa_d;
    logic [DW-1:0]   wd_q, wd_d;
    logic [DW-1:0]   pix_q [N];
    logic            win_we, fill, last;
    logic [AW-1:0]   tl_a, tr_a, bl_a, br_a;
    logic [DW-1:0]   p_tl, p_tr, p_bl, p_br, n_tl, n_tr, n_bl, n_br;
    logic [DW-1:0]   m1, m2, mx, l1, l2, mn, avg;
    logic [DW+1:0]   sum;
    logic [1:0]      r;

    assign tl_a = {y_q - Y1, x_q - X1};
    assign tr_a = {y_q - Y1, x_q};
    assign bl_a = {y_q, x_q - X1};
    assign br_a = {y_q, x_q};
    assign p_tl = pix_q[tl_a];
    assign p_tr = pix_q[tr_a];
    assign p_bl = pix_q[bl_a];
    assign p_br = pix_q[br_a];

    assign m1  = p_tl > p_tr ? p_tl : p_tr;
    assign m2  = p_bl > p_br ? p_bl : p_br;
    assign mx  = m1 > m2 ? m1 : m2;
    assign l1  = p_tl < p_tr ? p_tl : p_tr;
    assign l2  = p_bl < p_br ? p_bl : p_br;
    assign mn  = l1 < l2 ? l1 : l2;
    assign sum = {2'b00, p_tl} + {2'b00, p_tr} + {2'b00, p_bl} + {2'b00, p_br};
    assign avg = DW'(sum >> 2);

    // r selects CCW / CW / MX / MY; FILL overrides with the registered result
    assign fill = state_q == FILL;
    assign r    = cmd_q[1:0];
    assign n_tl = fill ? res_q : r == 2'd0 ? p_tr : (r == 2'd3 ? p_tr : p_bl);
    assign n_tr = fill ? res_q : r == 2'd0 ? p_br : (r == 2'd2 ? p_br : p_tl);
    assign n_bl = fill ? res_q : r == 2'd0 ? p_tl : (r == 2'd1 ? p_br : (r == 2'd2 ? p_tl : p_br));
    assign n_br = fill ? res_q : r == 2'd0 ? p_bl : (r == 2'd1 ? p_tr : (r == 2'd2 ? p_tr : p_bl));
    assign last = wa_q == LAST;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        x_d     = x_q;
        y_d     = y_q;
        rcnt_d  = rcnt_q;
        res_d   = res_q;
        rd_d    = 1'b0;
        ra_d    = ra_q;
        wv_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        win_we  = 1'b0;
        case (state_q)
            LOAD: begin
                rd_d   = rcnt_q < N_C;
                ra_d   = rcnt_q < N_C ? rcnt_q[AW-1:0] : ra_q;
                rcnt_d = rcnt_q < N_C ? rcnt_q + R1 : rcnt_q;
                if (cap_v_q && cap_a_q == LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            IDLE: begin
                if (cmd_valid && !busy_q) begin
                    busy_d  = 1'b1;
                    cmd_d   = cmd;
                    state_d = cmd == 4'd0 ? WRITE :
                              (cmd >= 4'd5 && cmd <= 4'd7) ? CALC :
                              cmd == 4'd12 ? LOAD : EXEC;
                    if (cmd == 4'd0) begin
                        wv_d = 1'b1;
                        wa_d = '0;
                        wd_d = pix_q[0];
                    end
                    if (cmd == 4'd12) begin
                        rcnt_d = R1;
                        rd_d   = 1'b1;
                        ra_d   = '0;
                    end
                end
            end
            EXEC: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                win_we  = cmd_q[3:2] == 2'b10;
                y_d = (cmd_q == 4'd1 && y_q > Y1) ? y_q - Y1 :
                      (cmd_q == 4'd2 && y_q < YMAX) ? y_q + Y1 :
                      cmd_q == 4'd13 ? YC : y_q;
                x_d = (cmd_q == 4'd3 && x_q > X1) ? x_q - X1 :
                      (cmd_q == 4'd4 && x_q < XMAX) ? x_q + X1 :
                      cmd_q == 4'd13 ? XC : x_q;
            end
            CALC: begin
                res_d   = cmd_q == 4'd5 ? mx : cmd_q == 4'd6 ? mn : avg;
                state_d = FILL;
            end
            FILL: begin
                win_we  = 1'b1;
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            WRITE: begin
                wv_d    = !last;
                done_d  = last;
                wa_d    = last ? wa_q : wa_q + A1;
                wd_d    = last ? wd_q : pix_q[wa_q + A1];
                state_d = last ? DONE : WRITE;
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOAD;
            cmd_q   <= '0;
            x_q     <= XC;
            y_q     <= YC;
            rcnt_q  <= '0;
            cap_v_q <= 1'b0;
            cap_a_q <= '0;
            res_q   <= '0;
            rd_q    <= 1'b0;
            ra_q    <= '0;
            wv_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rcnt_q  <= rcnt_d;
            cap_v_q <= rd_q;
            cap_a_q <= ra_q;
            res_q   <= res_d;
            rd_q    <= rd_d;
            ra_q    <= ra_d;
            wv_q    <= wv_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // ROM data lands one cycle after its address, so captures trail the read strobe by a cycle
    always_ff @(posedge clk) begin
        if (cap_v_q) pix_q[cap_a_q] <= irom_q;
        if (win_we) begin
            pix_q[tl_a] <= n_tl;
            pix_q[tr_a] <= n_tr;
            pix_q[bl_a] <= n_bl;
            pix_q[br_a] <= n_br;
        end
    end

    assign irom_rd    = rd_q;
    assign irom_a     = ra_q;
    assign iram_valid = wv_q;
    assign iram_a     = wa_q;
    assign iram_d     = wd_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule
